// File: rtl/ptw_arb_pkg.sv
// Shared definitions for the page-table-walker arbiter.
//   state_t : arbiter FSM states (IDLE, WAIT, DRAIN)
//   PORT_I / PORT_D : requester ids for the instruction and data TLBs
package ptw_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/ptw_arbiter_rr_arb2.sv
// Two-way round-robin grant.
//   clk, rst : clock, synchronous active-high reset
//   req[1:0] : request vector indexed by port id
//   update   : load the current grant into the last-grant register
//   grant    : chosen port id (combinational)
// Last-grant resets to PORT_D so PORT_I wins the first tie.
module rr_arb2
    import ptw_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant
);

    logic last;

    always_comb begin
        grant = PORT_D;
        if (req == 2'b11)
            grant = ~last;
        else if (req[PORT_I])
            grant = PORT_I;
    end

    always_ff @(posedge clk) begin
        if (rst)
            last <= PORT_D;
        else if (update)
            last <= grant;
    end

endmodule

// File: rtl/ptw_arbiter.sv
// Shares one page-table walker between the ITLB and DTLB.
//   Itlb_/Dtlb_miss_req, _miss_vpn : miss pulse and VPN per TLB
//   Itlb_/Dtlb_fill_valid, _fill_ppn : registered one-cycle fill per TLB
//   Tlb_flush : drops pending misses and any in-flight result
//   Ptw_req, Ptw_vpn : registered walk request to the walker
//   Ptw_valid, Ptw_ppn : walker result
//   Arb_busy : high whenever the FSM is not IDLE
// One pending slot per TLB; identical-VPN misses are merged into one walk.
module ptw_arbiter
    import ptw_arb_pkg::*;
#(
    parameter int VPN_WIDTH = 20,
    parameter int PPN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Itlb_miss_req,
    input  logic [VPN_WIDTH-1:0] Itlb_miss_vpn,
    output logic                 Itlb_fill_valid,
    output logic [PPN_WIDTH-1:0] Itlb_fill_ppn,
    input  logic                 Dtlb_miss_req,
    input  logic [VPN_WIDTH-1:0] Dtlb_miss_vpn,
    output logic                 Dtlb_fill_valid,
    output logic [PPN_WIDTH-1:0] Dtlb_fill_ppn,
    input  logic                 Tlb_flush,
    output logic                 Ptw_req,
    output logic [VPN_WIDTH-1:0] Ptw_vpn,
    input  logic                 Ptw_valid,
    input  logic [PPN_WIDTH-1:0] Ptw_ppn,
    output logic                 Arb_busy
);

    state_t               state;
    logic                 owner;
    logic                 i_valid, d_valid;
    logic [VPN_WIDTH-1:0] i_vpn, d_vpn;
    logic                 grant;
    logic                 issue;
    logic                 resp;
    logic                 merge;
    logic                 fill_i, fill_d;

    assign issue    = (state == ST_IDLE) && (i_valid || d_valid) && !Tlb_flush;
    assign resp     = (state == ST_WAIT) && Ptw_valid && !Tlb_flush;
    assign Arb_busy = (state != ST_IDLE);

    // Merge eligibility uses slot contents as they stand this cycle, so a
    // miss arriving together with the result is latched but not merged.
    assign merge  = (owner == PORT_I) ? (d_valid && (d_vpn == i_vpn))
                                      : (i_valid && (i_vpn == d_vpn));
    assign fill_i = resp && ((owner == PORT_I) || merge);
    assign fill_d = resp && ((owner == PORT_D) || merge);

    rr_arb2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    ({d_valid, i_valid}),
        .update (issue),
        .grant  (grant)
    );

    // Pending slots: a full slot ignores further misses; flush wins over a
    // same-cycle miss.
    always_ff @(posedge clk) begin
        if (rst || Tlb_flush) begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            if (rst) begin
                i_vpn <= '0;
                d_vpn <= '0;
            end
        end else begin
            if (fill_i) begin
                i_valid <= 1'b0;
            end else if (!i_valid && Itlb_miss_req) begin
                i_valid <= 1'b1;
                i_vpn   <= Itlb_miss_vpn;
            end
            if (fill_d) begin
                d_valid <= 1'b0;
            end else if (!d_valid && Dtlb_miss_req) begin
                d_valid <= 1'b1;
                d_vpn   <= Dtlb_miss_vpn;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            owner           <= PORT_I;
            Ptw_req         <= 1'b0;
            Ptw_vpn         <= '0;
            Itlb_fill_valid <= 1'b0;
            Itlb_fill_ppn   <= '0;
            Dtlb_fill_valid <= 1'b0;
            Dtlb_fill_ppn   <= '0;
        end else begin
            Ptw_req         <= 1'b0;
            Itlb_fill_valid <= 1'b0;
            Dtlb_fill_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        Ptw_req <= 1'b1;
                        Ptw_vpn <= (grant == PORT_D) ? d_vpn : i_vpn;
                        owner   <= grant;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (Tlb_flush) begin
                        // A result arriving with the flush is simply dropped.
                        state <= Ptw_valid ? ST_IDLE : ST_DRAIN;
                    end else if (Ptw_valid) begin
                        if (fill_i) begin
                            Itlb_fill_valid <= 1'b1;
                            Itlb_fill_ppn   <= Ptw_ppn;
                        end
                        if (fill_d) begin
                            Dtlb_fill_valid <= 1'b1;
                            Dtlb_fill_ppn   <= Ptw_ppn;
                        end
                        state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (Ptw_valid)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
